ac_skip_datapath_p: RTL and testbench

// Parametrised datapath for the AC load voltage controller (half-cycle skipping).
// - Decides on every mains zero-crossing whether the next half-cycle is fired or skipped.
// - Random mode: LFSR vs user level UI. Sigma-delta mode: deterministic accumulator.
// - Enforces DC balance: each skipped positive half is matched by a skipped negative half, and vice versa.
// - Sits between the zero-cross detector and the triac/SSR gate driver; replaces the fixed 4-bit/21-bit datapath.

---
 rtl/ac_ctrl_pkg.sv | 32 +++
 rtl/lfsr_prng_p.sv | 35 +++
 rtl/ac_skip_datapath_p.sv | 138 +++++++++++++
 tb/tb_ac_skip_datapath_p.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_ctrl_pkg.sv
// Shared types and helpers for the AC half-cycle skipping controller.
package ac_ctrl_pkg;

    typedef enum logic {
        MODE_RANDOM      = 1'b0,
        MODE_SIGMA_DELTA = 1'b1
    } mode_e;

    localparam int unsigned TAPS_W = 16;

    // Maximal-length right-shift Galois masks, bit i set means tap on x^(i+1)
    function automatic logic [TAPS_W-1:0] default_taps(input int unsigned width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h000C;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_prng_p.sv
// Galois LFSR with seed load (zero seed mapped to 1) and step enable.
module lfsr_prng_p
    import ac_ctrl_pkg::*;
#(
    parameter int unsigned       PRNG_W = 4,
    parameter logic [PRNG_W-1:0] TAPS   = PRNG_W'(default_taps(PRNG_W))
) (
    input  logic              SYS_CLK,
    input  logic              A_RESET,
    input  logic              load_seed_i,
    input  logic [PRNG_W-1:0] seed_i,
    input  logic              step_i,
    output logic [PRNG_W-1:0] state_o
);

    logic [PRNG_W-1:0] state_q, state_d;

    // Seed load wins over stepping; the all-zero lock-up state is never entered
    always_comb begin
        state_d = state_q;
        if (load_seed_i) begin
            state_d = (seed_i == '0) ? PRNG_W'(1) : seed_i;
        end else if (step_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge SYS_CLK or posedge A_RESET) begin
        if (A_RESET) state_q <= PRNG_W'(1);
        else         state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/ac_skip_datapath_p.sv
// Half-cycle fire/skip decision datapath with DC-balance debt counters.
module ac_skip_datapath_p
    import ac_ctrl_pkg::*;
#(
    parameter int unsigned       PRNG_W = 4,
    parameter int unsigned       CNT_W  = 21,
    parameter logic [PRNG_W-1:0] TAPS   = PRNG_W'(default_taps(PRNG_W))
) (
    input  logic              SYS_CLK,
    input  logic              A_RESET,
    input  logic              ZC_POS,
    input  logic              ZC_NEG,
    input  logic [PRNG_W-1:0] UI,
    input  logic              MODE,
    input  logic [PRNG_W-1:0] SEED,
    input  logic              LOAD_SEED,
    input  logic              SCLR,
    output logic              FIRE_POS,
    output logic              FIRE_NEG,
    output logic [CNT_W-1:0]  R_POS,
    output logic [CNT_W-1:0]  R_NEG,
    output logic              R_POS_FLAG,
    output logic              R_NEG_FLAG,
    output logic              P_POS_FLAG,
    output logic              P_NEG_FLAG,
    output logic [PRNG_W-1:0] PRNG,
    output logic              ZC_ERR
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              fire_pos_q, fire_pos_d, fire_neg_q, fire_neg_d;
    logic              p_pos_q, p_pos_d, p_neg_q, p_neg_d;
    logic              zc_err_q, zc_err_d;
    logic [CNT_W-1:0]  r_pos_q, r_pos_d, r_neg_q, r_neg_d;
    logic [PRNG_W-1:0] acc_q, acc_d;
    logic [PRNG_W-1:0] prng_c;
    logic [PRNG_W:0]   sum_c;
    logic              decide_c, sd_mode_c, lfsr_step_c;

    assign sd_mode_c   = (mode_e'(MODE) == MODE_SIGMA_DELTA);
    assign sum_c       = {1'b0, acc_q} + {1'b0, UI};
    assign decide_c    = sd_mode_c ? sum_c[PRNG_W] : (prng_c <= UI);
    assign lfsr_step_c = (ZC_POS ^ ZC_NEG) & ~SCLR;

    lfsr_prng_p #(
        .PRNG_W (PRNG_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .SYS_CLK     (SYS_CLK),
        .A_RESET     (A_RESET),
        .load_seed_i (LOAD_SEED),
        .seed_i      (SEED),
        .step_i      (lfsr_step_c),
        .state_o     (prng_c)
    );

    // Next-state: clear, conflicting strobes, then per-polarity fire/skip/repay
    always_comb begin
        fire_pos_d = fire_pos_q;
        fire_neg_d = fire_neg_q;
        p_pos_d    = p_pos_q;
        p_neg_d    = p_neg_q;
        zc_err_d   = zc_err_q;
        r_pos_d    = r_pos_q;
        r_neg_d    = r_neg_q;
        acc_d      = acc_q;

        if (SCLR) begin
            fire_pos_d = 1'b0;
            fire_neg_d = 1'b0;
            p_pos_d    = 1'b0;
            p_neg_d    = 1'b0;
            zc_err_d   = 1'b0;
            r_pos_d    = '0;
            r_neg_d    = '0;
            acc_d      = '0;
        end else if (ZC_POS && ZC_NEG) begin
            zc_err_d = 1'b1;
        end else if (ZC_POS) begin
            fire_neg_d = 1'b0;
            if (r_neg_q != '0) begin
                fire_pos_d = 1'b0;
                r_neg_d    = r_neg_q - CNT_W'(1);
            end else begin
                if (sd_mode_c) acc_d = sum_c[PRNG_W-1:0];
                fire_pos_d = decide_c;
                if (!decide_c && (r_pos_q != CNT_MAX)) r_pos_d = r_pos_q + CNT_W'(1);
            end
            p_pos_d = fire_pos_d;
        end else if (ZC_NEG) begin
            fire_pos_d = 1'b0;
            if (r_pos_q != '0) begin
                fire_neg_d = 1'b0;
                r_pos_d    = r_pos_q - CNT_W'(1);
            end else begin
                if (sd_mode_c) acc_d = sum_c[PRNG_W-1:0];
                fire_neg_d = decide_c;
                if (!decide_c && (r_neg_q != CNT_MAX)) r_neg_d = r_neg_q + CNT_W'(1);
            end
            p_neg_d = fire_neg_d;
        end
    end

    always_ff @(posedge SYS_CLK or posedge A_RESET) begin
        if (A_RESET) begin
            fire_pos_q <= 1'b0;
            fire_neg_q <= 1'b0;
            p_pos_q    <= 1'b0;
            p_neg_q    <= 1'b0;
            zc_err_q   <= 1'b0;
            r_pos_q    <= '0;
            r_neg_q    <= '0;
            acc_q      <= '0;
        end else begin
            fire_pos_q <= fire_pos_d;
            fire_neg_q <= fire_neg_d;
            p_pos_q    <= p_pos_d;
            p_neg_q    <= p_neg_d;
            zc_err_q   <= zc_err_d;
            r_pos_q    <= r_pos_d;
            r_neg_q    <= r_neg_d;
            acc_q      <= acc_d;
        end
    end

    assign FIRE_POS   = fire_pos_q;
    assign FIRE_NEG   = fire_neg_q;
    assign R_POS      = r_pos_q;
    assign R_NEG      = r_neg_q;
    assign R_POS_FLAG = (r_pos_q != '0);
    assign R_NEG_FLAG = (r_neg_q != '0);
    assign P_POS_FLAG = p_pos_q;
    assign P_NEG_FLAG = p_neg_q;
    assign PRNG       = prng_c;
    assign ZC_ERR     = zc_err_q;

endmodule

// File: tb/tb_ac_skip_datapath_p.sv
// Directed + randomized bench for ac_skip_datapath_p against a behavioural model.
module tb_ac_skip_datapath_p;

    localparam int unsigned PW = 4;

    logic          SYS_CLK = 1'b0;
    logic          A_RESET, ZC_POS, ZC_NEG, MODE, LOAD_SEED, SCLR;
    logic [PW-1:0] UI, SEED;

    logic          FIRE_POS, FIRE_NEG, R_POS_FLAG, R_NEG_FLAG, P_POS_FLAG, P_NEG_FLAG, ZC_ERR;
    logic [20:0]   R_POS, R_NEG;
    logic [PW-1:0] PRNG;

    logic          s_fire_pos, s_fire_neg, s_rpf, s_rnf, s_ppf, s_pnf, s_err;
    logic [1:0]    s_r_pos, s_r_neg;
    logic [PW-1:0] s_prng;

    int total = 0;
    int bad   = 0;

    // Behavioural model: index 0 = 21-bit counters, index 1 = 2-bit counters
    int m_rpos[2], m_rneg[2], m_acc[2];
    bit m_fpos[2], m_fneg[2], m_ppos[2], m_pneg[2];
    int m_cmax[2] = '{2097151, 3};
    int m_lfsr;
    bit m_err;

    always #5 SYS_CLK = ~SYS_CLK;

    ac_skip_datapath_p #(.PRNG_W(PW), .CNT_W(21)) dut (
        .SYS_CLK(SYS_CLK), .A_RESET(A_RESET), .ZC_POS(ZC_POS), .ZC_NEG(ZC_NEG),
        .UI(UI), .MODE(MODE), .SEED(SEED), .LOAD_SEED(LOAD_SEED), .SCLR(SCLR),
        .FIRE_POS(FIRE_POS), .FIRE_NEG(FIRE_NEG), .R_POS(R_POS), .R_NEG(R_NEG),
        .R_POS_FLAG(R_POS_FLAG), .R_NEG_FLAG(R_NEG_FLAG), .P_POS_FLAG(P_POS_FLAG),
        .P_NEG_FLAG(P_NEG_FLAG), .PRNG(PRNG), .ZC_ERR(ZC_ERR)
    );

    ac_skip_datapath_p #(.PRNG_W(PW), .CNT_W(2)) dut_s (
        .SYS_CLK(SYS_CLK), .A_RESET(A_RESET), .ZC_POS(ZC_POS), .ZC_NEG(ZC_NEG),
        .UI(UI), .MODE(MODE), .SEED(SEED), .LOAD_SEED(LOAD_SEED), .SCLR(SCLR),
        .FIRE_POS(s_fire_pos), .FIRE_NEG(s_fire_neg), .R_POS(s_r_pos), .R_NEG(s_r_neg),
        .R_POS_FLAG(s_rpf), .R_NEG_FLAG(s_rnf), .P_POS_FLAG(s_ppf),
        .P_NEG_FLAG(s_pnf), .PRNG(s_prng), .ZC_ERR(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next state = current state times x^-1 modulo x^4 + x^3 + 1
    function automatic int lfsr_next(input int s);
        return (s % 2 == 1) ? ((s / 2) ^ 12) : (s / 2);
    endfunction

    task automatic model_clear(input bit full_reset);
        for (int k = 0; k < 2; k++) begin
            m_rpos[k] = 0; m_rneg[k] = 0; m_acc[k] = 0;
            m_fpos[k] = 0; m_fneg[k] = 0; m_ppos[k] = 0; m_pneg[k] = 0;
        end
        m_err = 0;
        if (full_reset) m_lfsr = 1;
    endtask

    task automatic model_zc(input bit p, input bit n);
        if (p && n) begin
            m_err = 1;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int sum;
            bit d;
            sum = m_acc[k] + int'(UI);
            d   = MODE ? (sum >= 16) : (m_lfsr <= int'(UI));
            if (p) begin
                m_fneg[k] = 0;
                if (m_rneg[k] > 0) begin
                    m_fpos[k] = 0;
                    m_rneg[k]--;
                end else begin
                    if (MODE) m_acc[k] = sum % 16;
                    m_fpos[k] = d;
                    if (!d && m_rpos[k] < m_cmax[k]) m_rpos[k]++;
                end
                m_ppos[k] = m_fpos[k];
            end else begin
                m_fpos[k] = 0;
                if (m_rpos[k] > 0) begin
                    m_fneg[k] = 0;
                    m_rpos[k]--;
                end else begin
                    if (MODE) m_acc[k] = sum % 16;
                    m_fneg[k] = d;
                    if (!d && m_rneg[k] < m_cmax[k]) m_rneg[k]++;
                end
                m_pneg[k] = m_fneg[k];
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".fire_pos"}, 32'(FIRE_POS), 32'(m_fpos[0]));
        chk({tag, ".fire_neg"}, 32'(FIRE_NEG), 32'(m_fneg[0]));
        chk({tag, ".r_pos"}, 32'(R_POS), 32'(m_rpos[0]));
        chk({tag, ".r_neg"}, 32'(R_NEG), 32'(m_rneg[0]));
        chk({tag, ".r_pos_flag"}, 32'(R_POS_FLAG), 32'(m_rpos[0] != 0));
        chk({tag, ".r_neg_flag"}, 32'(R_NEG_FLAG), 32'(m_rneg[0] != 0));
        chk({tag, ".p_pos"}, 32'(P_POS_FLAG), 32'(m_ppos[0]));
        chk({tag, ".p_neg"}, 32'(P_NEG_FLAG), 32'(m_pneg[0]));
        chk({tag, ".prng"}, 32'(PRNG), 32'(m_lfsr));
        chk({tag, ".zc_err"}, 32'(ZC_ERR), 32'(m_err));
        chk({tag, ".s_fire_pos"}, 32'(s_fire_pos), 32'(m_fpos[1]));
        chk({tag, ".s_fire_neg"}, 32'(s_fire_neg), 32'(m_fneg[1]));
        chk({tag, ".s_r_pos"}, 32'(s_r_pos), 32'(m_rpos[1]));
        chk({tag, ".s_r_neg"}, 32'(s_r_neg), 32'(m_rneg[1]));
    endtask

    task automatic do_zc(input string tag, input bit p, input bit n);
        @(negedge SYS_CLK);
        ZC_POS = p;
        ZC_NEG = n;
        @(negedge SYS_CLK);
        ZC_POS = 1'b0;
        ZC_NEG = 1'b0;
        model_zc(p, n);
        chk_all(tag);
    endtask

    task automatic do_sclr();
        @(negedge SYS_CLK);
        SCLR = 1'b1;
        @(negedge SYS_CLK);
        SCLR = 1'b0;
        model_clear(1'b0);
        chk_all("sclr");
    endtask

    task automatic do_seed(input logic [PW-1:0] s);
        @(negedge SYS_CLK);
        SEED      = s;
        LOAD_SEED = 1'b1;
        @(negedge SYS_CLK);
        LOAD_SEED = 1'b0;
        m_lfsr = (s == 0) ? 1 : int'(s);
        chk_all("seed");
    endtask

    initial begin
        int fp, fn, mfp, mfn, distinct;
        bit seen[16];
        logic [PW-1:0] prng_saved;
        bit p;

        A_RESET = 1'b1; ZC_POS = 1'b0; ZC_NEG = 1'b0; MODE = 1'b0;
        LOAD_SEED = 1'b0; SCLR = 1'b0; UI = '0; SEED = '0;
        model_clear(1'b1);
        repeat (3) @(negedge SYS_CLK);
        chk_all("reset");
        A_RESET = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        chk_all("idle");
        chk("idle.prng_one", 32'(PRNG), 32'd1);

        // UI=0 never fires: skip positive, then repay with the negative half
        UI = 4'd0;
        do_zc("ui0_pos", 1'b1, 1'b0);
        chk("ui0_pos.r_pos_const", 32'(R_POS), 32'd1);
        do_zc("ui0_neg", 1'b0, 1'b1);
        chk("ui0_neg.r_pos_const", 32'(R_POS), 32'd0);
        chk("ui0_neg.fire_neg_const", 32'(FIRE_NEG), 32'd0);

        // Full power: every half fires
        UI = 4'd15;
        for (int i = 0; i < 8; i++) begin
            p = (i % 2 == 0);
            do_zc("ui15", p, !p);
            chk("ui15.fire_const", 32'(p ? FIRE_POS : FIRE_NEG), 32'd1);
        end

        // Asynchronous reset drops the gate between clock edges
        do_zc("pre_arst", 1'b1, 1'b0);
        chk("pre_arst.fire_pos_const", 32'(FIRE_POS), 32'd1);
        @(negedge SYS_CLK);
        #2 A_RESET = 1'b1;
        #1;
        chk("arst.fire_pos_async", 32'(FIRE_POS), 32'd0);
        chk("arst.prng_async", 32'(PRNG), 32'd1);
        model_clear(1'b1);
        @(negedge SYS_CLK);
        A_RESET = 1'b0;
        chk_all("post_arst");

        // Zero seed maps to 1; LFSR period is 15 with distinct nonzero states
        do_seed(4'd0);
        chk("seed0.prng_const", 32'(PRNG), 32'd1);
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            do_zc("period", (i % 2 == 0), (i % 2 != 0));
            seen[PRNG] = 1'b1;
        end
        distinct = 0;
        for (int i = 1; i < 16; i++) if (seen[i]) distinct++;
        chk("period.distinct", 32'(distinct), 32'd15);
        chk("period.zero_seen", 32'(seen[0]), 32'd0);
        chk("period.back_to_one", 32'(PRNG), 32'd1);

        // Random mode, random levels and polarity (repeats allowed)
        do_seed(4'd9);
        chk("seed9.prng_const", 32'(PRNG), 32'd9);
        for (int i = 0; i < 60; i++) begin
            UI = PW'($urandom_range(0, 15));
            p  = bit'($urandom_range(0, 1));
            do_zc("rand", p, !p);
        end

        // Sigma-delta, half power, strict alternation
        do_sclr();
        MODE = 1'b1;
        UI   = 4'd8;
        fp = 0; fn = 0; mfp = 0; mfn = 0;
        for (int i = 0; i < 32; i++) begin
            p = (i % 2 == 0);
            do_zc("sd8", p, !p);
            fp  += int'(FIRE_POS);
            fn  += int'(FIRE_NEG);
            mfp += int'(m_fpos[0]);
            mfn += int'(m_fneg[0]);
            chk("sd8.both_debt", 32'((R_POS != 0) && (R_NEG != 0)), 32'd0);
        end
        chk("sd8.fired_pos", 32'(fp), 32'(mfp));
        chk("sd8.fired_neg", 32'(fn), 32'(mfn));
        chk("sd8.balance", 32'(fp - fn), 32'(mfp - mfn));

        // Sigma-delta, random levels
        do_sclr();
        for (int i = 0; i < 40; i++) begin
            UI = PW'($urandom_range(0, 15));
            p  = bit'($urandom_range(0, 1));
            do_zc("sd_rand", p, !p);
        end

        // Conflicting strobes: only ZC_ERR moves; SCLR clears it but keeps the LFSR
        do_sclr();
        MODE = 1'b0;
        UI   = 4'd0;
        do_zc("err_pre", 1'b1, 1'b0);
        do_zc("err_both", 1'b1, 1'b1);
        chk("err_both.zc_err_const", 32'(ZC_ERR), 32'd1);
        chk("err_both.r_pos_const", 32'(R_POS), 32'd1);
        UI = 4'd15;
        do_zc("err_sticky", 1'b0, 1'b1);
        chk("err_sticky.zc_err_const", 32'(ZC_ERR), 32'd1);
        prng_saved = PRNG;
        do_sclr();
        chk("sclr.zc_err_const", 32'(ZC_ERR), 32'd0);
        chk("sclr.prng_kept", 32'(PRNG), 32'(m_lfsr));
        chk("sclr.prng_unchanged", 32'(PRNG), 32'(prng_saved));

        // Saturation of the 2-bit debt counter, then repayment without underflow
        UI = 4'd0;
        for (int i = 0; i < 6; i++) do_zc("sat_pos", 1'b1, 1'b0);
        chk("sat.s_r_pos_const", 32'(s_r_pos), 32'd3);
        chk("sat.r_pos_const", 32'(R_POS), 32'd6);
        for (int i = 0; i < 3; i++) do_zc("sat_neg", 1'b0, 1'b1);
        chk("sat.s_r_pos_drained", 32'(s_r_pos), 32'd0);
        do_zc("sat_neg4", 1'b0, 1'b1);
        chk("sat.s_r_pos_no_underflow", 32'(s_r_pos), 32'd0);
        chk("sat.s_r_neg_const", 32'(s_r_neg), 32'd1);
        chk("sat.r_pos_const2", 32'(R_POS), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
